// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings for the load/store alignment unit.
//   - request size codes (byte / half / word; 2'b11 is illegal)
//   - response FSM state encoding
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RESP = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/lsu_load_format.sv
// lsu_load_format: combinational load-data formatting.
// Ports:
//   rdata   - raw 32-bit memory word
//   addr_lo - byte offset within the word
//   size    - access size code (lsu_pkg SZ_*)
//   uns     - 1 = zero-extend, 0 = sign-extend
//   data    - right-justified, extended load result
module lsu_load_format
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_lane = rdata[7:0];
      2'd1:    byte_lane = rdata[15:8];
      2'd2:    byte_lane = rdata[23:16];
      default: byte_lane = rdata[31:24];
    endcase
    half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    case (size)
      SZ_BYTE: data = {{24{~uns & byte_lane[7]}}, byte_lane};
      SZ_HALF: data = {{16{~uns & half_lane[15]}}, half_lane};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_align.sv
// lsu_mem_align: aligns CPU byte/half/word accesses onto a 32-bit
// sync-read/sync-write memory port and formats the load response.
// Ports:
//   clk, rst_n                  - clock, async active-low reset
//   req_valid/req_ready         - request handshake
//   req_we, req_addr, req_size,
//   req_unsigned, req_wdata     - request fields (byte address)
//   mem_addr, mem_be, mem_wdata,
//   mem_we, mem_rdata           - memory data port (1-cycle read latency)
//   rsp_valid/rsp_ready         - response handshake
//   rsp_rdata, rsp_err          - formatted load data, error flag
module lsu_mem_align
  import lsu_pkg::*;
#(
  parameter int AWIDTH = 12,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [AWIDTH+1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [DWIDTH-1:0] req_wdata,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [DWIDTH-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DWIDTH-1:0] rsp_rdata,
  output logic              rsp_err
);

  state_t      state, state_next;
  logic        accept;
  logic        req_err;
  logic        mem_access;
  logic [3:0]  be_raw;

  logic [1:0]  addr_lo_reg;
  logic [1:0]  size_reg;
  logic        uns_reg;
  logic        we_reg;
  logic        err_reg;
  logic [31:0] hold_reg;

  logic [31:0] load_data;
  logic [31:0] fmt_data;

  // A new request can enter whenever the response slot frees this cycle.
  assign req_ready = (state == ST_IDLE) || rsp_ready;
  assign accept    = req_valid && req_ready;

  always_comb begin
    case (req_size)
      SZ_BYTE: begin req_err = 1'b0;            be_raw = 4'b0001 << req_addr[1:0]; end
      SZ_HALF: begin req_err = req_addr[0];     be_raw = 4'b0011 << req_addr[1:0]; end
      SZ_WORD: begin req_err = |req_addr[1:0];  be_raw = 4'b1111;                  end
      default: begin req_err = 1'b1;            be_raw = 4'b0000;                  end
    endcase
  end

  always_comb begin
    case (req_size)
      SZ_BYTE: mem_wdata = {4{req_wdata[7:0]}};
      SZ_HALF: mem_wdata = {2{req_wdata[15:0]}};
      default: mem_wdata = req_wdata;
    endcase
  end

  // Erroneous requests still complete the handshake but never touch memory.
  assign mem_access = accept && !req_err;
  assign mem_addr   = req_addr[AWIDTH+1:2];
  assign mem_we     = mem_access && req_we;
  assign mem_be     = mem_access ? be_raw : 4'b0000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_lo_reg <= 2'd0;
      size_reg    <= 2'd0;
      uns_reg     <= 1'b0;
      we_reg      <= 1'b0;
      err_reg     <= 1'b0;
    end else if (accept) begin
      addr_lo_reg <= req_addr[1:0];
      size_reg    <= req_size;
      uns_reg     <= req_unsigned;
      we_reg      <= req_we;
      err_reg     <= req_err;
    end
  end

  lsu_load_format u_fmt (
    .rdata   (mem_rdata),
    .addr_lo (addr_lo_reg),
    .size    (size_reg),
    .uns     (uns_reg),
    .data    (load_data)
  );

  // Stores and errors report zero data.
  assign fmt_data = (we_reg || err_reg) ? 32'd0 : load_data;

  // mem_rdata is only valid in the RESP cycle; freeze it if the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_reg <= 32'd0;
    end else if (state == ST_RESP && !rsp_ready) begin
      hold_reg <= fmt_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = ST_RESP;
      ST_RESP,
      ST_HOLD: begin
        if (rsp_ready)       state_next = accept ? ST_RESP : ST_IDLE;
        else                 state_next = ST_HOLD;
      end
      default:               state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    rsp_valid = 1'b0;
    rsp_rdata = 32'd0;
    rsp_err   = 1'b0;
    case (state)
      ST_RESP: begin rsp_valid = 1'b1; rsp_rdata = fmt_data; rsp_err = err_reg; end
      ST_HOLD: begin rsp_valid = 1'b1; rsp_rdata = hold_reg; rsp_err = err_reg; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_mem_align.sv
module tb_lsu_mem_align;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [13:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic [11:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mem [0:4095];

  always #5 clk = ~clk;

  lsu_mem_align #(.AWIDTH(12), .DWIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .mem_addr     (mem_addr),
    .mem_be       (mem_be),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .mem_rdata    (mem_rdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  // Sync-read / sync-write memory with byte enables.
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (mem_we && mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    mem_rdata <= mem[mem_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (actual running, required finished)");
    $fatal(1);
  end

  // One accepted access followed by its response one cycle later.
  task automatic access(input string name, input logic we, input logic [13:0] addr,
                        input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_rdata, input logic exp_err);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wdata;
    #1;
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_err++; $display("FAIL %s req_ready: actual %b required 1", name, req_ready);
    end
    n_vec++;
    if (mem_be !== exp_be) begin
      n_err++; $display("FAIL %s mem_be: actual %b required %b", name, mem_be, exp_be);
    end
    n_vec++;
    if (mem_we !== (we && !exp_err)) begin
      n_err++; $display("FAIL %s mem_we: actual %b required %b", name, mem_we, we && !exp_err);
    end
    n_vec++;
    if (mem_addr !== addr[13:2]) begin
      n_err++; $display("FAIL %s mem_addr: actual %0d required %0d", name, mem_addr, addr[13:2]);
    end
    if (we && !exp_err) begin
      n_vec++;
      if (mem_wdata !== exp_wdata) begin
        n_err++; $display("FAIL %s mem_wdata: actual %h required %h", name, mem_wdata, exp_wdata);
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    n_vec++;
    if (rsp_valid !== 1'b1) begin
      n_err++; $display("FAIL %s rsp_valid: actual %b required 1", name, rsp_valid);
    end
    n_vec++;
    if (rsp_rdata !== exp_rdata) begin
      n_err++; $display("FAIL %s rsp_rdata: actual %h required %h", name, rsp_rdata, exp_rdata);
    end
    n_vec++;
    if (rsp_err !== exp_err) begin
      n_err++; $display("FAIL %s rsp_err: actual %b required %b", name, rsp_err, exp_err);
    end
    $display("txn %-14s we=%b addr=%h size=%b be=%b rdata=%h err=%b",
             name, we, addr, size, exp_be, rsp_rdata, rsp_err);
  endtask

  task automatic test_reset();
    #1;
    n_vec++;
    if (rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL reset rsp_valid: actual %b required 0", rsp_valid);
    end
    n_vec++;
    if (rsp_err !== 1'b0 || rsp_rdata !== 32'd0) begin
      n_err++; $display("FAIL reset rsp: actual err=%b rdata=%h required 0/0", rsp_err, rsp_rdata);
    end
    n_vec++;
    if (mem_we !== 1'b0 || mem_be !== 4'b0000) begin
      n_err++; $display("FAIL reset mem: actual we=%b be=%b required 0/0000", mem_we, mem_be);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_err++; $display("FAIL reset req_ready: actual %b required 1", req_ready);
    end
    $display("txn reset           released");
  endtask

  task automatic test_word();
    access("st_word_a0", 1, 14'h0A0, 2'b10, 0, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 32'h0, 0);
    access("ld_word_a0", 0, 14'h0A0, 2'b10, 0, 32'h0, 4'b1111, 32'h0, 32'hDEADBEEF, 0);
  endtask

  task automatic test_byte_half();
    // Word at 0xA0 becomes 0x80ADBEEF.
    access("st_byte_a3", 1, 14'h0A3, 2'b00, 0, 32'h12345680, 4'b1000, 32'h80808080, 32'h0, 0);
    access("ld_sbyte_a3", 0, 14'h0A3, 2'b00, 0, 32'h0, 4'b1000, 32'h0, 32'hFFFFFF80, 0);
    access("ld_ubyte_a3", 0, 14'h0A3, 2'b00, 1, 32'h0, 4'b1000, 32'h0, 32'h00000080, 0);
    access("ld_sbyte_a1", 0, 14'h0A1, 2'b00, 0, 32'h0, 4'b0010, 32'h0, 32'hFFFFFFBE, 0);
    access("ld_shalf_a2", 0, 14'h0A2, 2'b01, 0, 32'h0, 4'b1100, 32'h0, 32'hFFFF80AD, 0);
    // Word at 0xA0 becomes 0x80AD1234.
    access("st_half_a0", 1, 14'h0A0, 2'b01, 0, 32'hFFFF1234, 4'b0011, 32'h12341234, 32'h0, 0);
    access("ld_uhalf_a0", 0, 14'h0A0, 2'b01, 1, 32'h0, 4'b0011, 32'h0, 32'h00001234, 0);
    access("ld_ubyte_a2", 0, 14'h0A2, 2'b00, 1, 32'h0, 4'b0100, 32'h0, 32'h000000AD, 0);
  endtask

  task automatic test_error();
    access("ld_half_51", 0, 14'h051, 2'b01, 0, 32'h0, 4'b0000, 32'h0, 32'h0, 1);
    access("ld_word_52", 0, 14'h052, 2'b10, 0, 32'h0, 4'b0000, 32'h0, 32'h0, 1);
    access("st_size11_50", 1, 14'h050, 2'b11, 0, 32'hFFFFFFFF, 4'b0000, 32'h0, 32'h0, 1);
    access("ld_word_50", 0, 14'h050, 2'b10, 0, 32'h0, 4'b1111, 32'h0, 32'h11111111, 0);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 14'h050;
    @(negedge clk);
    req_addr = 14'h054;
    rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) rsp_ready = 1'b1;
      #1;
      n_vec++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h11111111) begin
        n_err++; $display("FAIL b2b_hold%0d rsp: actual v=%b d=%h required 1/11111111",
                          c, rsp_valid, rsp_rdata);
      end
      n_vec++;
      if (req_ready !== (c == 2)) begin
        n_err++; $display("FAIL b2b_hold%0d req_ready: actual %b required %b", c, req_ready, c == 2);
      end
      $display("txn b2b_cycle%0d     rsp=%h req_ready=%b", c, rsp_rdata, req_ready);
      @(negedge clk);
    end
    req_addr = 14'h058;
    #1;
    n_vec++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h22222222 || req_ready !== 1'b1) begin
      n_err++; $display("FAIL b2b_second: actual v=%b d=%h rdy=%b required 1/22222222/1",
                        rsp_valid, rsp_rdata, req_ready);
    end
    $display("txn b2b_second      rsp=%h", rsp_rdata);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    n_vec++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h33333333) begin
      n_err++; $display("FAIL b2b_third: actual v=%b d=%h required 1/33333333", rsp_valid, rsp_rdata);
    end
    $display("txn b2b_third       rsp=%h", rsp_rdata);
    @(negedge clk);
    #1;
    n_vec++;
    if (rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL b2b_idle rsp_valid: actual %b required 0", rsp_valid);
    end
  endtask

  task automatic test_reset_hold();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 14'h054;
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    @(negedge clk);
    #1;
    n_vec++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h22222222) begin
      n_err++; $display("FAIL rst_hold pre: actual v=%b d=%h required 1/22222222", rsp_valid, rsp_rdata);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
      n_err++; $display("FAIL rst_hold during: actual v=%b d=%h e=%b required 0/0/0",
                        rsp_valid, rsp_rdata, rsp_err);
    end
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_err++; $display("FAIL rst_hold req_ready: actual %b required 1", req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL rst_hold release: actual rdy=%b v=%b required 1/0", req_ready, rsp_valid);
    end
    $display("txn reset_in_hold   dropped");
    rsp_ready = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = 2'b00;
    req_unsigned = 1'b0; req_wdata = 32'd0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    test_word();
    test_byte_half();
    access("st_word_50", 1, 14'h050, 2'b10, 0, 32'h11111111, 4'b1111, 32'h11111111, 32'h0, 0);
    access("st_word_54", 1, 14'h054, 2'b10, 0, 32'h22222222, 4'b1111, 32'h22222222, 32'h0, 0);
    access("st_word_58", 1, 14'h058, 2'b10, 0, 32'h33333333, 4'b1111, 32'h33333333, 32'h0, 0);
    test_error();
    test_back_to_back();
    test_reset_hold();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_mem_align.md
LSU_MEM_ALIGN -- requirements
Module: lsu_mem_align

Interface
REQ-001 Parameter AWIDTH, default 12, memory word-address width.
REQ-002 Parameter DWIDTH, default 32, data width; only 32 is supported.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 req_valid  input  1  CPU access request present.
REQ-006 req_ready  output  1  request accepted when req_valid && req_ready at a rising edge.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  AWIDTH+2  byte address.
REQ-009 req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-010 req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-011 req_wdata  input  32  store data, right-justified.
REQ-012 mem_addr  output  AWIDTH  word address to the data port of the sync-read/sync-write memory.
REQ-013 mem_be  output  4  byte enables.
REQ-014 mem_wdata  output  32  lane-aligned store data.
REQ-015 mem_we  output  1  write enable.
REQ-016 mem_rdata  input  32  memory read data; valid one cycle after the address is sampled.
REQ-017 rsp_valid  output  1  response present.
REQ-018 rsp_ready  input  1  consumer accepts the response.
REQ-019 rsp_rdata  output  32  formatted load data; 0 for stores and errors.
REQ-020 rsp_err  output  1  misaligned or illegal-size access.

Function
REQ-021 mem_* outputs are combinational from req_* in the accept cycle: mem_addr = req_addr[AWIDTH+1:2], mem_we = req_we; in every non-accept cycle, and for erroneous requests, mem_we = 0 and mem_be = 0.
REQ-022 Byte enables: byte -> 4'b0001 << addr[1:0]; half -> 4'b0011 << addr[1:0]; word -> 4'b1111.
REQ-023 Store data lane replication: byte is replicated to all 4 lanes; half is replicated to both halves; word is passed through.
REQ-024 Error: half with addr[0] = 1, word with addr[1:0] != 0, or size 11; no memory access, and the response carries rsp_err = 1 and rsp_rdata = 0.
REQ-025 At accept, register addr[1:0], size, unsigned, we and err for response formatting.
REQ-026 FSM states: IDLE, RESP, HOLD. Accept moves to RESP.
REQ-027 RESP: rsp_valid = 1 and rsp_rdata is formatted from live mem_rdata; if rsp_ready = 0, capture the formatted data into the hold register and move to HOLD.
REQ-028 HOLD: rsp_valid = 1 from the hold register, held stable until rsp_ready.
REQ-029 req_ready = (state == IDLE) || rsp_ready, so one access per cycle is sustained back-to-back.
REQ-030 RESP or HOLD with rsp_ready = 1: a new accept in the same cycle goes to RESP, otherwise to IDLE.
REQ-031 Load formatting: select lane addr[1:0] (byte) or addr[1] (half), then zero- or sign-extend to 32 bits.
REQ-032 Latency: rsp_valid is asserted exactly 1 cycle after accept; responses are returned in request order.

Reset
REQ-033 Asserting rst_n low forces state IDLE, rsp_valid = 0, rsp_err = 0, and clears the hold and registered request fields to 0.
REQ-034 A response in flight when reset asserts is dropped; req_ready = 1 is the first value after reset release.

Structure
REQ-035 Package lsu_pkg holds the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state encoding.
REQ-036 Sub-module lsu_load_format: combinational lane select plus extension, instantiated once.

Verification
REQ-037 Store word 0xDEADBEEF at byte address 0xA0, then load word at 0xA0 -> mem_be 1111, mem_addr 40, then rsp_rdata = 0xDEADBEEF one cycle after the load is accepted.
REQ-038 Store byte 0x80 at 0xA3, then signed byte load -> mem_be 1000, mem_wdata 0x80808080, then rsp_rdata = 0xFFFFFF80; an unsigned byte load returns 0x00000080.
REQ-039 Load half at 0x51 -> rsp_err = 1, rsp_rdata = 0, mem_be = 0000, mem_we = 0; load word at 0x52 gives the same result.
REQ-040 Back-to-back loads at 0x50, 0x54, 0x58 with rsp_ready held low for 2 cycles after the first response -> first response held stable in HOLD, req_ready = 0 while stalled, then 3 in-order responses.
REQ-041 Pulse rst_n low while in HOLD -> rsp_valid = 0 immediately, and req_ready = 1 after release.
